// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle carried from vga_timing_gen to the overlay stage and the DAC.
// The master modport drives the pointers, syncs and strobes; consumers use the slave modport.
interface vga_timing_gen_if;
  logic [9:0] abs_ptrR;
  logic [9:0] abs_ptrC;
  logic       hsync;
  logic       vsync;
  logic       display_en;
  logic       pix_stb;
  logic       line_start;
  logic       frame_start;

  modport master (
    output abs_ptrR, abs_ptrC, hsync, vsync,
    output display_en, pix_stb, line_start, frame_start
  );

  modport slave (
    input abs_ptrR, abs_ptrC, hsync, vsync,
    input display_en, pix_stb, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running raster timing source (640x480 @ 800x525 by default).
// Horizontal/vertical counters are decoded into registered pointers, syncs, display
// enable and pixel/line/frame strobes, all with the same 1-clk counter-to-output latency.
// Optional build macro VGA_PIX_DIV2_EN: each pixel is held for two clks, with the
// counters advancing only every other clk.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic              clk,
  input  logic              rst_b,
  vga_timing_gen_if.master  vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT_END    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT_END    = 10'(V_ACTIVE);
  localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] r_hCnt;
  logic [9:0] r_vCnt;
  logic       w_adv;
  logic       w_newPix;
  logic       w_hWrap;
  logic       w_vWrap;

  logic       w_hsyncAct;
  logic       w_vsyncAct;
  logic       w_displayEn;
  logic       w_lineStart;
  logic       w_frameStart;

  logic [9:0] r_ptrR;
  logic [9:0] r_ptrC;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_displayEn;
  logic       r_pixStb;
  logic       r_lineStart;
  logic       r_frameStart;

`ifdef VGA_PIX_DIV2_EN
  logic r_phase;

  // Pixel-rate divider: counters advance on odd clks, so the counter value being decoded
  // is fresh whenever the phase is 0 (including the very first clk after reset).
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_phase <= 1'b0;
    end else begin
      r_phase <= ~r_phase;
    end
  end

  assign w_adv    = r_phase;
  assign w_newPix = ~r_phase;
`else
  assign w_adv    = 1'b1;
  assign w_newPix = 1'b1;
`endif

  assign w_hWrap = (r_hCnt == H_LAST);
  assign w_vWrap = (r_vCnt == V_LAST);

  // Raster counters: column wraps at the end of each line, row steps only on that wrap.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_hCnt <= '0;
      r_vCnt <= '0;
    end else if (w_adv) begin
      if (w_hWrap) begin
        r_hCnt <= '0;
        r_vCnt <= w_vWrap ? '0 : r_vCnt + 10'd1;
      end else begin
        r_hCnt <= r_hCnt + 10'd1;
      end
    end
  end

  // Decode the current counter position into the next values of the registered outputs.
  always_comb begin
    w_hsyncAct   = 1'b0;
    w_vsyncAct   = 1'b0;
    w_displayEn  = 1'b0;
    w_lineStart  = 1'b0;
    w_frameStart = 1'b0;
    w_hsyncAct   = (r_hCnt >= H_SYNC_START) && (r_hCnt < H_SYNC_END);
    w_vsyncAct   = (r_vCnt >= V_SYNC_START) && (r_vCnt < V_SYNC_END);
    w_displayEn  = (r_hCnt < H_ACT_END) && (r_vCnt < V_ACT_END);
    w_lineStart  = w_newPix && (r_hCnt == 10'd0);
    w_frameStart = w_lineStart && (r_vCnt == 10'd0);
  end

  // Output registers: reloaded every clk so all outputs stay mutually aligned.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_ptrR       <= '0;
      r_ptrC       <= '0;
      r_hsync      <= ~SYNC_POL;
      r_vsync      <= ~SYNC_POL;
      r_displayEn  <= 1'b0;
      r_pixStb     <= 1'b0;
      r_lineStart  <= 1'b0;
      r_frameStart <= 1'b0;
    end else begin
      r_ptrR       <= r_vCnt;
      r_ptrC       <= r_hCnt;
      r_hsync      <= w_hsyncAct ? SYNC_POL : ~SYNC_POL;
      r_vsync      <= w_vsyncAct ? SYNC_POL : ~SYNC_POL;
      r_displayEn  <= w_displayEn;
      r_pixStb     <= w_newPix;
      r_lineStart  <= w_lineStart;
      r_frameStart <= w_frameStart;
    end
  end

  assign vga.abs_ptrR    = r_ptrR;
  assign vga.abs_ptrC    = r_ptrC;
  assign vga.hsync       = r_hsync;
  assign vga.vsync       = r_vsync;
  assign vga.display_en  = r_displayEn;
  assign vga.pix_stb     = r_pixStb;
  assign vga.line_start  = r_lineStart;
  assign vga.frame_start = r_frameStart;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: one instance with the standard 640x480 geometry and
// active-low syncs, one with a tiny geometry and active-high syncs so that frame and
// vsync wraps are reached quickly. Expected outputs come from a cycle-count model.
module tb_vga_timing_gen;

`ifdef VGA_PIX_DIV2_EN
  localparam int DIV = 2;
`else
  localparam int DIV = 1;
`endif

  logic clk;
  logic rst_b;

  int assertCount;
  int failCount;
  int edgeCount;

  vga_timing_gen_if vgaStd ();
  vga_timing_gen_if vgaSmall ();

  vga_timing_gen dutStd (
    .clk   (clk),
    .rst_b (rst_b),
    .vga   (vgaStd.master)
  );

  vga_timing_gen #(
    .H_ACTIVE (16), .H_FP (2), .H_SYNC (4), .H_BP (3),
    .V_ACTIVE (6),  .V_FP (1), .V_SYNC (2), .V_BP (2),
    .SYNC_POL (1'b1)
  ) dutSmall (
    .clk   (clk),
    .rst_b (rst_b),
    .vga   (vgaSmall.master)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs after k clk edges since reset release (k = 0 means still in reset).
  // Layout: [25:16] row, [15:6] col, hsync, vsync, display_en, pix_stb, line_start, frame_start.
  function automatic logic [25:0] expOut(int k, int hA, int hF, int hS, int hB,
                                         int vA, int vF, int vS, int vB, bit pol);
    int  hT, vT, p, c, r;
    bit  stb, hsA, vsA, de;
    hT = hA + hF + hS + hB;
    vT = vA + vF + vS + vB;
    if (k == 0) return {10'd0, 10'd0, ~pol, ~pol, 4'b0000};
    p   = (k - 1) / DIV;
    stb = ((k - 1) % DIV) == 0;
    c   = p % hT;
    r   = (p / hT) % vT;
    hsA = (c >= hA + hF) && (c < hA + hF + hS);
    vsA = (r >= vA + vF) && (r < vA + vF + vS);
    de  = (c < hA) && (r < vA);
    return {10'(r), 10'(c), hsA ? pol : ~pol, vsA ? pol : ~pol, de, stb,
            stb && (c == 0), stb && (c == 0) && (r == 0)};
  endfunction

  task automatic checkField(string tag, int act, int exp);
    assertCount++;
    assert (act === exp) else begin
      failCount++;
      $error("[TB] FAIL %s at edge %0d: observed %0d, expected %0d", tag, edgeCount, act, exp);
    end
  endtask

  task automatic checkInst(string inst, logic [25:0] act, logic [25:0] exp);
    checkField({inst, ".abs_ptrR"},    int'(act[25:16]), int'(exp[25:16]));
    checkField({inst, ".abs_ptrC"},    int'(act[15:6]),  int'(exp[15:6]));
    checkField({inst, ".hsync"},       int'(act[5]),     int'(exp[5]));
    checkField({inst, ".vsync"},       int'(act[4]),     int'(exp[4]));
    checkField({inst, ".display_en"},  int'(act[3]),     int'(exp[3]));
    checkField({inst, ".pix_stb"},     int'(act[2]),     int'(exp[2]));
    checkField({inst, ".line_start"},  int'(act[1]),     int'(exp[1]));
    checkField({inst, ".frame_start"}, int'(act[0]),     int'(exp[0]));
  endtask

  task automatic checkOutput();
    checkInst("std", {vgaStd.abs_ptrR, vgaStd.abs_ptrC, vgaStd.hsync, vgaStd.vsync,
                      vgaStd.display_en, vgaStd.pix_stb, vgaStd.line_start, vgaStd.frame_start},
              expOut(edgeCount, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
    checkInst("small", {vgaSmall.abs_ptrR, vgaSmall.abs_ptrC, vgaSmall.hsync, vgaSmall.vsync,
                        vgaSmall.display_en, vgaSmall.pix_stb, vgaSmall.line_start,
                        vgaSmall.frame_start},
              expOut(edgeCount, 16, 2, 4, 3, 6, 1, 2, 2, 1'b1));
  endtask

  // Run n clk edges, checking both instances on every falling edge.
  task automatic applyStimulus(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rst_b) edgeCount++;
      checkOutput();
    end
  endtask

  // Assert reset between edges, confirm the asynchronous clear, hold, then release.
  task automatic applyReset(int holdCycles);
    @(negedge clk);
    #1;
    rst_b     = 1'b0;
    edgeCount = 0;
    #1;
    checkOutput();
    applyStimulus(holdCycles);
    rst_b = 1'b1;
  endtask

  // Directed sequence with randomized run lengths and reset points.
  initial begin
    assertCount = 0;
    failCount   = 0;
    edgeCount   = 0;
    rst_b       = 1'b0;

    applyStimulus(3);
    rst_b = 1'b1;

    applyStimulus(1700 * DIV);

    for (int n = 0; n < 5; n++) begin
      applyReset(int'($urandom_range(1, 4)));
      applyStimulus(int'($urandom_range(20, 3000)));
    end

    applyReset(2);
    applyStimulus(900 * DIV);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
